// File: rtl/div_iter_pkg.sv
// div_iter_pkg: shared types for the iterative divider.
//   i1 / i32 / i64 : scalar and word typedefs used across the execute stage
//   div_state_t    : divider FSM states (IDLE, BUSY, DONE), 2-bit encoding
//   cnt_width()    : iteration counter width for a given operand width
package div_iter_pkg;

  typedef logic        i1;
  typedef logic [31:0] i32;
  typedef logic [63:0] i64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Wide enough to count 0..WIDTH inclusive.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/div_iter_step.sv
// div_iter_step: one combinational radix-2 restoring division step.
//   r        : current partial remainder
//   q        : quotient shift register (dividend bits still enter from its MSB)
//   divisor  : divisor magnitude
//   r_next   : partial remainder after this step
//   q_next   : q shifted left with the new quotient bit in bit 0
module div_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] r_shift;
  logic [WIDTH:0] diff;
  logic           fits;

  always_comb begin
    // Keep the remainder's MSB: with a divisor above 2^(WIDTH-1) the shifted
    // remainder can need WIDTH+1 bits before the subtraction.
    r_shift = {r, q[WIDTH-1]};
    diff    = r_shift - {1'b0, divisor};
    // Because r < divisor is maintained, diff stays below 2^WIDTH whenever
    // the subtraction is valid, so the top bit is a pure borrow flag.
    fits    = ~diff[WIDTH];
    r_next  = fits ? diff[WIDTH-1:0] : r_shift[WIDTH-1:0];
    q_next  = {q[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/div_iter.sv
// div_iter: multi-cycle unsigned radix-2 restoring divider.
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset
//   valid  : request, held high by the requester while the divide is wanted
//   a, b   : dividend / divisor magnitudes (latched when the operation starts)
//   done   : one-cycle pulse, c holds the finished result
//   c      : {remainder, quotient}, registered, held between operations
//   busy   : high while iterating
// Optional build macro DIV_EARLY_OUT_EN: b==0 or a<b finish straight from
// IDLE without iterating; results are identical, only latency changes.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] c,
  output logic               busy
);

  localparam int CNT_W = cnt_width(WIDTH);

  div_state_t       state;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] divisor;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  div_iter_step #(.WIDTH(WIDTH)) u_step (
    .r       (r),
    .q       (q),
    .divisor (divisor),
    .r_next  (r_next),
    .q_next  (q_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      done    <= 1'b0;
      busy    <= 1'b0;
      c       <= '0;
      r       <= '0;
      q       <= '0;
      divisor <= '0;
      count   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (valid) begin
            q       <= a;
            divisor <= b;
            r       <= '0;
            count   <= '0;
            state   <= BUSY;
            busy    <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
            // Trivial cases: quotient is all ones (b==0) or zero (a<b), and
            // the remainder is a in both.
            if (b == '0 || a < b) begin
              c     <= {a, {WIDTH{b == '0}}};
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
`endif
          end
        end
        BUSY: begin
          if (!valid) begin
            // Requester withdrew: abandon silently, c untouched.
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            r     <= r_next;
            q     <= q_next;
            count <= count + CNT_W'(1);
            if (count == CNT_W'(WIDTH - 1)) begin
              c     <= {r_next, q_next};
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
